// File: rtl/l1d_refill_ctrl_if.sv
// Next-level memory port of the L1D refill controller.
//   mem_req_valid/we/addr/wdata : request from the controller, held until mem_req_ready
//   mem_req_ready               : memory accepts the request this cycle
//   mem_rvalid/mem_rdata        : returned read beats of a line burst
// modport master = controller side, modport slave = memory side.
interface l1d_refill_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req_valid;
  logic                  mem_req_we;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [31:0]           mem_req_wdata;
  logic                  mem_req_ready;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/l1d_refill_ctrl.sv
// L1D miss handler: optional dirty-victim writeback (one single-beat write
// per beat, data read from the L1D data array), then a line burst refill
// written beat by beat into the data array, tag install, one-cycle ack.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   miss_valid/miss_addr            miss from lookup, held until miss_ack
//   victim_dirty/victim_addr        victim info, latched with the miss
//   miss_ack, busy                  completion pulse, not-IDLE flag
//   arr_rd_en/arr_rd_beat/arr_rdata victim read (data one cycle later)
//   arr_wr_en/arr_wr_beat/arr_wdata refill write into the data array
//   tag_wr_en                       install tag for the latched miss
//   mem                             next-level memory port (master)
module l1d_refill_ctrl #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int LINE_BYTES = 16,
  localparam int BEATS      = LINE_BYTES / 4,
  localparam int BEAT_W     = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  input  logic                  victim_dirty,
  input  logic [ADDR_WIDTH-1:0] victim_addr,
  output logic                  miss_ack,
  output logic                  busy,
  output logic                  arr_rd_en,
  output logic [BEAT_W-1:0]     arr_rd_beat,
  input  logic [31:0]           arr_rdata,
  output logic                  arr_wr_en,
  output logic [BEAT_W-1:0]     arr_wr_beat,
  output logic [31:0]           arr_wdata,
  output logic                  tag_wr_en,
  l1d_refill_ctrl_if.master     mem
);

  typedef enum logic [2:0] {
    IDLE, WB_RD, WB_WR, FILL_REQ, FILL, DONE
  } state_t;

  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

  state_t                state;
  logic [BEAT_W-1:0]     k;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [ADDR_WIDTH-1:0] vaddr_q;
  logic [31:0]           wdata_q;
  logic                  wb_first; // first cycle of WB_WR: arr_rdata is live

  logic fill_wr;
  assign fill_wr = (state == FILL) && mem.mem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      maddr_q  <= '0;
      vaddr_q  <= '0;
      wdata_q  <= '0;
      wb_first <= 1'b0;
    end else begin
      case (state)
        IDLE: if (miss_valid) begin
          maddr_q <= miss_addr;
          vaddr_q <= victim_addr;
          k       <= '0;
          state   <= victim_dirty ? WB_RD : FILL_REQ;
        end
        WB_RD: begin
          wb_first <= 1'b1;
          state    <= WB_WR;
        end
        WB_WR: begin
          wb_first <= 1'b0;
          if (wb_first) wdata_q <= arr_rdata;
          if (mem.mem_req_ready) begin
            if (k == LAST) begin
              k     <= '0;
              state <= FILL_REQ;
            end else begin
              k     <= k + 1'b1;
              state <= WB_RD;
            end
          end
        end
        FILL_REQ: if (mem.mem_req_ready) state <= FILL;
        FILL: if (mem.mem_rvalid) begin
          k <= k + 1'b1;  // wraps to 0 after the last beat
          if (k == LAST) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode from state/k; only the FILL write strobes follow mem_rvalid.
  assign busy        = (state != IDLE);
  assign miss_ack    = (state == DONE);
  assign arr_rd_en   = (state == WB_RD);
  assign arr_rd_beat = arr_rd_en ? k : '0;
  assign arr_wr_en   = fill_wr;
  assign arr_wr_beat = fill_wr ? k : '0;
  assign arr_wdata   = fill_wr ? mem.mem_rdata : '0;
  assign tag_wr_en   = fill_wr && (k == LAST);

  assign mem.mem_req_valid = (state == WB_WR) || (state == FILL_REQ);
  assign mem.mem_req_we    = (state == WB_WR);

  always_comb begin
    mem.mem_req_addr = '0;
    if (state == WB_WR)
      mem.mem_req_addr = vaddr_q + ADDR_WIDTH'({k, 2'b00});
    else if (state == FILL_REQ)
      mem.mem_req_addr = maddr_q & ~ADDR_WIDTH'(LINE_BYTES - 1);
  end

  // Array data is only valid in the first WB_WR cycle; afterwards the
  // captured copy keeps the write data stable under backpressure.
  always_comb begin
    mem.mem_req_wdata = '0;
    if (state == WB_WR) mem.mem_req_wdata = wb_first ? arr_rdata : wdata_q;
  end

endmodule

// File: tb/tb_l1d_refill_ctrl.sv
module tb_l1d_refill_ctrl;
  localparam int AW = 32;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          miss_valid, victim_dirty;
  logic [AW-1:0] miss_addr, victim_addr;
  logic          miss_ack, busy, arr_rd_en, arr_wr_en, tag_wr_en;
  logic [BW-1:0] arr_rd_beat, arr_wr_beat;
  logic [31:0]   arr_rdata, arr_wdata;

  l1d_refill_ctrl_if #(.ADDR_WIDTH(AW)) mif ();

  l1d_refill_ctrl #(.ADDR_WIDTH(AW), .LINE_BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_valid(miss_valid), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr),
    .miss_ack(miss_ack), .busy(busy),
    .arr_rd_en(arr_rd_en), .arr_rd_beat(arr_rd_beat), .arr_rdata(arr_rdata),
    .arr_wr_en(arr_wr_en), .arr_wr_beat(arr_wr_beat), .arr_wdata(arr_wdata),
    .tag_wr_en(tag_wr_en), .mem(mif)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"},      miss_ack, 0);
    chk({tag, "_busy"},     busy, 0);
    chk({tag, "_rd_en"},    arr_rd_en, 0);
    chk({tag, "_rd_beat"},  arr_rd_beat, 0);
    chk({tag, "_wr_en"},    arr_wr_en, 0);
    chk({tag, "_wr_beat"},  arr_wr_beat, 0);
    chk({tag, "_wdata"},    arr_wdata, 0);
    chk({tag, "_tag"},      tag_wr_en, 0);
    chk({tag, "_req_v"},    mif.mem_req_valid, 0);
    chk({tag, "_req_we"},   mif.mem_req_we, 0);
    chk({tag, "_req_addr"}, mif.mem_req_addr, 0);
    chk({tag, "_req_wd"},   mif.mem_req_wdata, 0);
  endtask

  typedef struct {
    logic [31:0] maddr;
    logic        dirty;
    logic [31:0] vaddr;
    int          rwait;   // ready held low this many cycles per request
    int          gap;     // idle cycles between read beats
    int          abort;   // stop after this many array writes (0 = run to ack)
    bit          keep;    // leave miss_valid high after ack (back-to-back)
    int          exp_ack; // cycle of miss_ack, cycle 0 = miss sampled
  } vec_t;

  vec_t tbl[8];

  // Drives one miss; every cycle: inputs at negedge, outputs sampled #1 later.
  task automatic run_txn(input vec_t v, input int t);
    int c = 0, req_idx = 0, req_wait = 0, wr_idx = 0, wr_drv = 0, rd_idx = 0;
    int gap_cnt = 0, nreq;
    bit rd_q = 0, fill_on = 0, done = 0, aborted = 0;
    logic [BW-1:0] rdb = '0;
    logic [31:0] h_addr = '0, h_wdata = '0, e_addr;
    logic h_we = 1'b0, e_we;
    logic [31:0] am[4], fd[4];
    nreq = v.dirty ? 5 : 1;
    for (int i = 0; i < 4; i++) begin
      am[i] = 32'hA000_0000 | (32'(t) << 8) | 32'(i);
      fd[i] = 32'hF000_0000 | (32'(t) << 8) | (32'(i) << 4);
    end
    while (!done && !aborted && c < 200) begin
      @(negedge clk);
      if (c == 0) begin
        miss_valid = 1'b1; miss_addr = v.maddr;
        victim_addr = v.vaddr; victim_dirty = v.dirty;
      end else begin
        miss_addr = 32'hDEAD_BEE0 ^ 32'(c);
        victim_addr = 32'hCAFE_0000; victim_dirty = ~v.dirty;
      end
      arr_rdata = rd_q ? am[rdb] : (32'hBAD0_0000 | 32'(c));
      if (fill_on && wr_drv < 4 && gap_cnt == 0) begin
        mif.mem_rvalid = 1'b1; mif.mem_rdata = fd[wr_drv];
        wr_drv++; gap_cnt = v.gap;
      end else begin
        mif.mem_rvalid = 1'b0; mif.mem_rdata = 32'h5EED_0000 | 32'(c);
        if (fill_on && gap_cnt > 0) gap_cnt--;
      end
      mif.mem_req_ready = 1'b0;
      #1;
      if (mif.mem_req_valid) begin
        if (req_wait > 0) begin
          chk("req_hold_addr", mif.mem_req_addr, h_addr);
          chk("req_hold_we", mif.mem_req_we, h_we);
          chk("req_hold_wdata", mif.mem_req_wdata, h_wdata);
        end else begin
          h_addr = mif.mem_req_addr; h_we = mif.mem_req_we; h_wdata = mif.mem_req_wdata;
        end
        if (req_wait == v.rwait) begin
          mif.mem_req_ready = 1'b1;
          e_we   = v.dirty && req_idx < 4;
          e_addr = e_we ? v.vaddr + 32'(4 * req_idx) : (v.maddr & ~32'hF);
          chk("req_count_bound", req_idx < nreq, 1);
          chk("req_we", mif.mem_req_we, e_we);
          chk("req_addr", mif.mem_req_addr, e_addr);
          if (e_we) chk("req_wdata", mif.mem_req_wdata, am[req_idx & 3]);
          if (!mif.mem_req_we) fill_on = 1;
          req_idx++; req_wait = 0;
        end else req_wait++;
      end
      chk("tag_wr_en", tag_wr_en, arr_wr_en && wr_idx == 3);
      chk("wr_en_vs_rvalid", arr_wr_en, mif.mem_rvalid);
      if (arr_wr_en) begin
        chk("wr_beat", arr_wr_beat, wr_idx);
        chk("wr_data", arr_wdata, fd[wr_idx & 3]);
        wr_idx++;
      end
      if (arr_rd_en) begin
        chk("rd_beat", arr_rd_beat, rd_idx);
        rd_idx++;
      end
      rd_q = arr_rd_en; rdb = arr_rd_beat;
      chk("busy", busy, c != 0);
      if (miss_ack) begin
        chk("ack_cycle", c, v.exp_ack);
        done = 1;
      end
      if (v.abort != 0 && wr_idx == v.abort) aborted = 1;
      c++;
    end
    if (aborted) return;
    chk("ack_seen", done, 1);
    chk("req_total", req_idx, nreq);
    chk("wr_total", wr_idx, 4);
    chk("rd_total", rd_idx, v.dirty ? 4 : 0);
    if (!v.keep) begin
      @(negedge clk);
      miss_valid = 1'b0; mif.mem_req_ready = 1'b0; mif.mem_rvalid = 1'b0;
      #1;
      chk("ack_one_cycle", miss_ack, 0);
      chk("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    tbl[0] = '{32'h0000_1234, 1'b0, 32'h0000_0000, 0, 0, 0, 1'b0, 6};   // clean
    tbl[1] = '{32'h0000_2468, 1'b1, 32'h0000_8000, 0, 0, 0, 1'b0, 14};  // dirty
    tbl[2] = '{32'h0000_3004, 1'b1, 32'h0000_8040, 3, 0, 0, 1'b0, 29};  // backpressure
    tbl[3] = '{32'h0000_44C8, 1'b0, 32'h0000_0000, 0, 1, 0, 1'b0, 9};   // gapped beats
    tbl[4] = '{32'h0000_5554, 1'b0, 32'h0000_0000, 0, 0, 2, 1'b0, 0};   // reset mid-fill
    tbl[5] = '{32'h0000_6010, 1'b0, 32'h0000_0000, 0, 0, 0, 1'b0, 6};   // after reset
    tbl[6] = '{32'h0000_7000, 1'b0, 32'h0000_0000, 0, 0, 0, 1'b1, 6};   // b2b first
    tbl[7] = '{32'h0000_710C, 1'b1, 32'h0000_9000, 0, 0, 0, 1'b0, 14};  // b2b second

    miss_valid = 1'b0; miss_addr = '0; victim_dirty = 1'b0; victim_addr = '0;
    arr_rdata = '0; mif.mem_req_ready = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        // stray read beats while idle must not touch the array
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          miss_valid = 1'b0; mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h1111_0000 | 32'(j);
          #1;
          chk("stray_wr_en", arr_wr_en, 0);
          chk("stray_wdata", arr_wdata, 0);
          chk("stray_busy", busy, 0);
        end
        mif.mem_rvalid = 1'b0;
      end
      run_txn(tbl[i], i);
      if (i == 4) begin
        @(negedge clk);
        mif.mem_rvalid = 1'b1; mif.mem_rdata = 32'h7777_7777;
        rst_n = 1'b0;
        #1;
        chk_zero("midfill_rst");
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          #1;
          chk("rst_hold_wr_en", arr_wr_en, 0);
          chk("rst_hold_ack", miss_ack, 0);
        end
        @(negedge clk);
        rst_n = 1'b1; mif.mem_rvalid = 1'b0; miss_valid = 1'b0;
        #1;
        chk("post_rst_busy", busy, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
